// File: rtl/sim_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// sim_run_ctrl_if
// Signal bundle between the run controller and the bench around riscv_top.
//
//   halt_req     : DUT end-of-program strobe (bench -> controller)
//   commit       : one pulse per retired instruction (bench -> controller)
//   dut_rst      : active-high reset for riscv_top (controller -> bench)
//   running      : high while the DUT is released and running
//   done         : sticky, run ended by halt_req
//   timeout      : sticky, run ended by the cycle limit
//   stall_err    : sticky, run ended by the commit-stall watchdog
//   cycle_count  : RUN cycles elapsed
//   commit_count : commits seen during RUN
//
// Modports: master = bench side, slave = run controller.
// ---------------------------------------------------------------------------
interface sim_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             halt_req;
    logic             commit;
    logic             dut_rst;
    logic             running;
    logic             done;
    logic             timeout;
    logic             stall_err;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] commit_count;

    modport master (
        output halt_req, commit,
        input  dut_rst, running, done, timeout, stall_err,
               cycle_count, commit_count
    );

    modport slave (
        input  halt_req, commit,
        output dut_rst, running, done, timeout, stall_err,
               cycle_count, commit_count
    );
endinterface

// File: rtl/sim_run_ctrl.sv
// ---------------------------------------------------------------------------
// sim_run_ctrl
// Bench-side run controller: holds riscv_top in reset for RST_CYCLES cycles,
// then counts run cycles and commits until the run ends by halt request,
// cycle timeout or commit-stall watchdog. The end cause is a sticky flag.
//
// Ports:
//   clk   : single clock, all logic on its rising edge
//   rst_n : synchronous active-low reset, restarts the whole sequence
//   bus   : sim_run_ctrl_if.slave (halt_req/commit in, status/counters out)
//
// Parameters:
//   RST_CYCLES     : cycles dut_rst stays high after rst_n rises (>= 1)
//   TIMEOUT_CYCLES : RUN cycles before timeout, 0 disables
//   STALL_CYCLES   : commit-free RUN cycles before stall error, 0 disables
//   CNT_W          : counter width (must match the interface CNT_W)
//
// Optional feature macro: SIM_RUN_CTRL_FINISH_EN
//   When defined, the block prints the end cause and counts on the first
//   cycle a terminal flag is high and then ends the simulation.
// ---------------------------------------------------------------------------
module sim_run_ctrl #(
    parameter int unsigned RST_CYCLES     = 25,
    parameter int unsigned TIMEOUT_CYCLES = 15000000,
    parameter int unsigned STALL_CYCLES   = 100000,
    parameter int          CNT_W          = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    sim_run_ctrl_if.slave bus
);

    // Elaboration checks: limits must be representable in the counters.
    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("sim_run_ctrl: RST_CYCLES must be >= 1");
    end
    if (CNT_W < 32 && (TIMEOUT_CYCLES >> CNT_W) != 0) begin : g_bad_timeout
        $error("sim_run_ctrl: TIMEOUT_CYCLES does not fit in CNT_W");
    end
    if (CNT_W < 32 && (STALL_CYCLES >> CNT_W) != 0) begin : g_bad_stall
        $error("sim_run_ctrl: STALL_CYCLES does not fit in CNT_W");
    end

    localparam int               HOLD_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  STALL_VAL   = CNT_W'(STALL_CYCLES);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT,
        ST_STALL
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  idle_cnt;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  commit_cnt;
    logic              dut_rst_q;
    logic              running_q;
    logic              done_q;
    logic              timeout_q;
    logic              stall_q;

    // Post-increment counter values used both for the update and the exit
    // checks of the same RUN edge.
    logic [CNT_W-1:0]  cycle_nxt;
    logic [CNT_W-1:0]  commit_nxt;
    logic [CNT_W-1:0]  idle_nxt;

    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        cycle_nxt  = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + 1'b1;
        commit_nxt = commit_cnt;
        idle_nxt   = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;
        if (bus.commit) begin
            commit_nxt = (commit_cnt == '1) ? commit_cnt : commit_cnt + 1'b1;
            idle_nxt   = '0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_HOLD;
            hold_cnt   <= '0;
            idle_cnt   <= '0;
            cycle_cnt  <= '0;
            commit_cnt <= '0;
            dut_rst_q  <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= ST_RUN;
                        dut_rst_q <= 1'b0;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Counters update even on the exiting edge.
                    cycle_cnt  <= cycle_nxt;
                    commit_cnt <= commit_nxt;
                    idle_cnt   <= idle_nxt;
                    if (bus.halt_req) begin
                        state     <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (TIMEOUT_VAL != '0 && cycle_nxt == TIMEOUT_VAL) begin
                        state     <= ST_TIMEOUT;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else if (STALL_VAL != '0 && idle_nxt == STALL_VAL) begin
                        state     <= ST_STALL;
                        running_q <= 1'b0;
                        stall_q   <= 1'b1;
                    end
                end
                // Terminal states hold everything until rst_n.
                default: ;
            endcase
        end
    end

    assign bus.dut_rst      = dut_rst_q;
    assign bus.running      = running_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.stall_err    = stall_q;
    assign bus.cycle_count  = cycle_cnt;
    assign bus.commit_count = commit_cnt;

`ifdef SIM_RUN_CTRL_FINISH_EN
    // Flags are sticky, so the first edge that sees one ends the simulation.
    always @(posedge clk) begin
        if (done_q || timeout_q || stall_q) begin
            $display("sim_run_ctrl: %s cycle_count=%0d commit_count=%0d",
                     done_q ? "DONE" : (timeout_q ? "TIMEOUT" : "STALL"),
                     cycle_cnt, commit_cnt);
            $finish;
        end
    end
`else
    // Termination is left to the bench; the flags carry the result.
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sim_run_ctrl
// Bench for sim_run_ctrl. Instance a uses RST=4, TIMEOUT=100, STALL=10;
// instance b disables both limits. Expected end records are queued while the
// stimulus is driven and compared when the DUT raises its end flag.
// ---------------------------------------------------------------------------
module tb_sim_run_ctrl;

    localparam int RST = 4;
    localparam int TO  = 100;
    localparam int ST  = 10;
    localparam int W   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_na, rst_nb;
    logic halt, commit;
    bit   sel;

    sim_run_ctrl_if #(.CNT_W(W)) bus_a ();
    sim_run_ctrl_if #(.CNT_W(W)) bus_b ();

    assign bus_a.halt_req = halt;
    assign bus_a.commit   = commit;
    assign bus_b.halt_req = halt;
    assign bus_b.commit   = commit;

    sim_run_ctrl #(
        .RST_CYCLES(RST), .TIMEOUT_CYCLES(TO), .STALL_CYCLES(ST), .CNT_W(W)
    ) dut_a (
        .clk(clk), .rst_n(rst_na), .bus(bus_a)
    );

    sim_run_ctrl #(
        .RST_CYCLES(RST), .TIMEOUT_CYCLES(0), .STALL_CYCLES(0), .CNT_W(W)
    ) dut_b (
        .clk(clk), .rst_n(rst_nb), .bus(bus_b)
    );

    // Observed outputs of the instance under test.
    logic         o_dut_rst, o_running, o_done, o_timeout, o_stall;
    logic [W-1:0] o_cyc, o_cmt;
    assign o_dut_rst = sel ? bus_b.dut_rst      : bus_a.dut_rst;
    assign o_running = sel ? bus_b.running      : bus_a.running;
    assign o_done    = sel ? bus_b.done         : bus_a.done;
    assign o_timeout = sel ? bus_b.timeout      : bus_a.timeout;
    assign o_stall   = sel ? bus_b.stall_err    : bus_a.stall_err;
    assign o_cyc     = sel ? bus_b.cycle_count  : bus_a.cycle_count;
    assign o_cmt     = sel ? bus_b.commit_count : bus_a.commit_count;

    typedef struct {
        logic done;
        logic timeout;
        logic stall;
        int   cyc;
        int   cmt;
    } exp_t;

    exp_t sb[$];
    int   nerr = 0;
    int   nchk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_dut_rst"}, 32'(o_dut_rst), 1);
        check({tag, "_running"}, 32'(o_running), 0);
        check({tag, "_done"},    32'(o_done),    0);
        check({tag, "_timeout"}, 32'(o_timeout), 0);
        check({tag, "_stall"},   32'(o_stall),   0);
        check({tag, "_cyc"},     32'(o_cyc),     0);
        check({tag, "_cmt"},     32'(o_cmt),     0);
    endtask

    // Called at the negedge where rst_n has just been released: the first
    // hold cycle is in progress. Checks the remaining hold and the RUN entry.
    task automatic hold_seq(input string tag);
        for (int i = 2; i <= RST; i++) begin
            @(negedge clk);
            check({tag, "_hold_rst"}, 32'(o_dut_rst), 1);
            check({tag, "_hold_run"}, 32'(o_running), 0);
        end
        @(negedge clk);
        check({tag, "_run_rst"}, 32'(o_dut_rst), 0);
        check({tag, "_run_on"},  32'(o_running), 1);
        check({tag, "_run_cyc"}, 32'(o_cyc),     0);
    endtask

    // Reset the selected instance for n cycles and walk it into RUN.
    task automatic apply_reset(input string tag, input int n);
        commit = 1'b0;
        halt   = 1'b0;
        if (sel) rst_nb = 1'b0; else rst_na = 1'b0;
        repeat (n) @(negedge clk);
        check_reset_vals(tag);
        if (sel) rst_nb = 1'b1; else rst_na = 1'b1;
        hold_seq(tag);
    endtask

    // Drive up to budget RUN cycles. A reference model tracks the counters and
    // pushes the expected end record on the cycle whose edge should end the run.
    task automatic run_case(input string tag, input int period, input int max_c,
                            input int halt_at, input int budget,
                            input int to_p, input int st_p, output bit ended);
        int cyc  = 0;
        int cmt  = 0;
        int idle = 0;
        bit c, h;
        exp_t e;
        ended = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            c = (period != 0) && (k % period == 0) && (cmt < max_c);
            h = (halt_at == k);
            commit = c;
            halt   = h;
            cyc++;
            if (c) begin cmt++; idle = 0; end else idle++;
            if (h) begin
                sb.push_back('{1'b1, 1'b0, 1'b0, cyc, cmt}); ended = 1'b1;
            end else if (to_p != 0 && cyc == to_p) begin
                sb.push_back('{1'b0, 1'b1, 1'b0, cyc, cmt}); ended = 1'b1;
            end else if (st_p != 0 && idle == st_p) begin
                sb.push_back('{1'b0, 1'b0, 1'b1, cyc, cmt}); ended = 1'b1;
            end
            @(negedge clk);
            if (ended) break;
            if (o_done || o_timeout || o_stall) begin
                check({tag, "_early_end"}, {29'd0, o_done, o_timeout, o_stall}, 0);
                break;
            end
        end
        commit = 1'b0;
        halt   = 1'b0;
        if (ended) begin
            e = sb.pop_front();
            check({tag, "_done"},    32'(o_done),    32'(e.done));
            check({tag, "_timeout"}, 32'(o_timeout), 32'(e.timeout));
            check({tag, "_stall"},   32'(o_stall),   32'(e.stall));
            check({tag, "_cyc"},     32'(o_cyc),     e.cyc);
            check({tag, "_cmt"},     32'(o_cmt),     e.cmt);
            check({tag, "_running"}, 32'(o_running), 0);
            check({tag, "_dut_rst"}, 32'(o_dut_rst), 0);
        end else begin
            check({tag, "_running"}, 32'(o_running), 1);
            check({tag, "_flags"},   {29'd0, o_done, o_timeout, o_stall}, 0);
            check({tag, "_cyc"},     32'(o_cyc),     cyc);
            check({tag, "_cmt"},     32'(o_cmt),     cmt);
        end
    endtask

    initial begin : guard
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "tb_sim_run_ctrl: time limit");
    end

    initial begin : main
        bit ended;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        commit = 1'b0;
        halt   = 1'b0;
        sel    = 1'b0;

        // Reset release: 3 cycles low, 4-cycle hold, first RUN cycle count.
        apply_reset("rel", 3);
        @(negedge clk);
        check("rel_first_cyc", 32'(o_cyc), 1);

        // Normal halt at RUN cycle 20 with a commit every cycle, then freeze.
        apply_reset("halt", 1);
        run_case("halt", 1, 1000, 20, 200, TO, ST, ended);
        commit = 1'b1;
        halt   = 1'b1;
        repeat (10) @(negedge clk);
        check("frz_cyc",  32'(o_cyc),  20);
        check("frz_cmt",  32'(o_cmt),  20);
        check("frz_done", 32'(o_done), 1);
        check("frz_run",  32'(o_running), 0);
        commit = 1'b0;
        halt   = 1'b0;

        // Timeout with a commit every 5th cycle.
        apply_reset("tmo", 1);
        run_case("tmo", 5, 1000, 0, 300, TO, ST, ended);

        // Stall: 3 commits, then silence.
        apply_reset("stall", 1);
        run_case("stall", 1, 3, 0, 300, TO, ST, ended);

        // Halt on the same edge the cycle limit is reached.
        apply_reset("simul", 1);
        run_case("simul", 1, 1000, TO, 300, TO, ST, ended);

        // Mid-run reset at RUN cycle 50.
        apply_reset("mid", 1);
        run_case("mid", 1, 1000, 0, 50, TO, ST, ended);
        rst_na = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst_na = 1'b1;
        hold_seq("mid_rst");

        // Both limits disabled: 1000 cycles without commit or halt.
        rst_na = 1'b0;
        sel    = 1'b1;
        apply_reset("nolim", 1);
        run_case("nolim", 0, 0, 0, 1000, 0, 0, ended);

        check("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Simulation-side run controller for the CPU top-level bench, and a parametrised successor to the bench's fixed reset-then-timeout sequence.
- Sequences the DUT reset for a configurable number of cycles.
- Counts run cycles and committed instructions.
- Ends the run in one of three ways: DUT halt request, cycle timeout, or commit-stall watchdog.
- Sits beside riscv_top in the bench, driving its reset and reporting a sticky end-of-run status.

Parameters:
- RST_CYCLES, 25, cycles dut_rst is held high after rst_n deasserts (must be >= 1).
- TIMEOUT_CYCLES, 15000000, RUN cycles before timeout (0 disables the timeout).
- STALL_CYCLES, 100000, consecutive RUN cycles without a commit before a stall error (0 disables the watchdog).
- CNT_W, 32, width of cycle_count, commit_count and the internal counters.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- halt_req  in  1  DUT end-of-program strobe; level or pulse, sampled each cycle.
- commit  in  1  one-cycle pulse per retired instruction.
- dut_rst  out  1  active-high reset to riscv_top.
- running  out  1  high while in RUN.
- done  out  1  sticky; run ended by halt_req.
- timeout  out  1  sticky; run ended by the cycle limit.
- stall_err  out  1  sticky; run ended by the stall watchdog.
- cycle_count  out  CNT_W  number of RUN cycles elapsed.
- commit_count  out  CNT_W  number of commits seen in RUN.

Behaviour:
- Reset (rst_n=0 at an edge): state=HOLD, hold_cnt=0, idle_cnt=0, counters=0, dut_rst=1, running=0, done=timeout=stall_err=0.
- Reset takes priority over every other event. Asserting rst_n low mid-run restarts the whole sequence.
- All outputs are registered. Each output reflects the state after the edge.
- HOLD:
  - dut_rst=1; hold_cnt increments each cycle.
  - At the edge where hold_cnt==RST_CYCLES-1, go to RUN.
  - dut_rst is therefore high for exactly RST_CYCLES cycles after rst_n rises.
  - halt_req and commit are ignored in HOLD.
- RUN: dut_rst=0, running=1. On each edge:
  - cycle_count increments (saturates at all-ones).
  - If commit=1: commit_count increments (saturating) and idle_cnt clears to 0. Otherwise idle_cnt increments (saturating).
  - Exit checks use the post-increment values, in priority order:
    1. halt_req=1 -> DONE
    2. TIMEOUT_CYCLES!=0 and new cycle_count==TIMEOUT_CYCLES -> TIMEOUT
    3. STALL_CYCLES!=0 and new idle_cnt==STALL_CYCLES -> STALL
  - The counter updates on the exiting edge still happen. A commit coinkident with halt_req is counted.
- DONE, TIMEOUT and STALL are terminal states:
  - running=0; dut_rst stays 0.
  - Counters are frozen; inputs are ignored.
  - The matching flag (done, timeout or stall_err) is 1. Exactly one flag is ever set.
  - Only rst_n leaves a terminal state.
- Flag timing: a flag rises the cycle after the triggering event is sampled.
- Final counts:
  - On timeout, cycle_count = TIMEOUT_CYCLES.
  - On stall, the final STALL_CYCLES cycles contain no commit.
- Widths: compare against the parameters after truncation to CNT_W. TIMEOUT_CYCLES and STALL_CYCLES must fit in CNT_W; an elaboration check is required.

Optional Feature:
Macro SIM_RUN_CTRL_FINISH_EN.
- Defined: on the first cycle any terminal flag is high, the block prints one $display line giving the cause (DONE/TIMEOUT/STALL), cycle_count and commit_count, then calls $finish. The bench needs no separate #delay $finish.
- Undefined: no system tasks are present. The flags alone report the result and the bench owns termination.

Test Plan (RST_CYCLES=4, TIMEOUT_CYCLES=100, STALL_CYCLES=10, CNT_W=16, macro undefined):
- Reset release: hold rst_n=0 for 3 cycles, then release -> dut_rst high for exactly 4 cycles after release; running rises on the 5th; cycle_count=1 at the end of the first RUN cycle.
- Normal halt: commit every cycle, halt_req at RUN cycle 20 -> done=1 the next cycle; cycle_count=20, commit_count=20; timeout=stall_err=0; counters frozen 10 cycles later.
- Timeout: commit every 5th cycle, no halt -> timeout=1, cycle_count=100, commit_count=20; done=stall_err=0.
- Stall: 3 commits, then commit=0 -> stall_err=1 exactly 10 cycles after the last commit; commit_count=3.
- Simultaneous: halt_req on the same edge as cycle_count reaches 100 -> done=1, timeout=0. Repeat with TIMEOUT_CYCLES=0, STALL_CYCLES=0 and no halt for 1000 cycles -> still running, all flags 0.
- Mid-run reset: rst_n low for 1 cycle at RUN cycle 50 -> outputs return to their reset values next cycle; the full 4-cycle hold repeats.
